// File: rtl/pacman_sprite_control.sv
// Pac-Man sprite engine: holds the 8x8 sprite position and streams its pixels (or an erase) to the frame buffer.
// Latency: draw = UPDATE + 64 pixels + DONE (67 cycles per request), clear = 66; one pixel per clock, all outputs registered.
// No backpressure: requests are only sampled in IDLE. PACMAN_TRANSPARENT_EN suppresses plot on bitmap-0 pixels of a draw.
module pacman_sprite_control #(
  parameter logic [11:0] SPRITE_COLOUR = 12'hFF0,
  parameter logic [11:0] BG_COLOUR     = 12'h000,
  parameter int          SCREEN_W      = 160,
  parameter int          SCREEN_H      = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        draw,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  load_x,
  input  logic [6:0]  load_y,
  input  logic        shift_h,
  input  logic        shift_v,
  input  logic [6:0]  shift_amount,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [11:0] colour_out,
  output logic        plot,
  output logic        complete,
  output logic [7:0]  posx,
  output logic [6:0]  posy
);

  typedef enum logic [1:0] {IDLE, UPDATE, PLOT, DONE} state_t;

  localparam logic signed [8:0] MAX_X = 9'(SCREEN_W - 8);
  localparam logic signed [8:0] MAX_Y = 9'(SCREEN_H - 8);

  state_t state_q, state_d;
  logic [5:0] cnt_q;
  logic       erase_q;

  logic signed [8:0] step, sum_x, sum_y;
  logic [8:0]        cx, cy;
  logic [7:0]        row_bits;
  logic              pix_bit;

  function automatic logic [7:0] sprite_row(input logic [2:0] r);
    case (r)
      3'd0, 3'd7: sprite_row = 8'h3C;
      3'd1, 3'd6: sprite_row = 8'h7E;
      3'd2, 3'd5: sprite_row = 8'hF8;
      default:    sprite_row = 8'hF0;
    endcase
  endfunction

  function automatic logic [8:0] clamp(input logic signed [8:0] v, input logic signed [8:0] hi);
    if (v < 0)       clamp = 9'd0;
    else if (v > hi) clamp = hi;
    else             clamp = v;
  endfunction

  // Signed arithmetic in 9 bits so a negative step can be detected and clamped rather than wrapped.
  always_comb begin
    step  = $signed({{2{shift_amount[6]}}, shift_amount});
    sum_x = $signed({1'b0, posx}) + (shift_h ? step : 9'sd0);
    sum_y = $signed({2'b00, posy}) + (shift_v ? step : 9'sd0);
    if (load) begin
      cx = clamp($signed({1'b0, load_x}), MAX_X);
      cy = clamp($signed({2'b00, load_y}), MAX_Y);
    end else begin
      cx = clamp(sum_x, MAX_X);
      cy = clamp(sum_y, MAX_Y);
    end
  end

  always_comb begin
    row_bits = sprite_row(cnt_q[5:3]);
    pix_bit  = row_bits[~cnt_q[2:0]];
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear)     state_d = PLOT;
        else if (draw) state_d = UPDATE;
      end
      UPDATE: state_d = PLOT;
      PLOT:   if (cnt_q == 6'd63) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= '0;
      erase_q    <= 1'b0;
      posx       <= '0;
      posy       <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      complete   <= 1'b0;
    end else begin
      plot     <= 1'b0;
      complete <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (clear || draw) erase_q <= clear;
        end
        UPDATE: begin
          posx <= cx[7:0];
          posy <= cy[6:0];
        end
        PLOT: begin
          x_out      <= posx + {5'b0, cnt_q[2:0]};
          y_out      <= posy + {4'b0, cnt_q[5:3]};
          colour_out <= (!erase_q && pix_bit) ? SPRITE_COLOUR : BG_COLOUR;
`ifdef PACMAN_TRANSPARENT_EN
          plot       <= erase_q || pix_bit;
`else
          plot       <= 1'b1;
`endif
          cnt_q      <= cnt_q + 6'd1;
        end
        DONE: complete <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_sprite_control.sv
// Bench for pacman_sprite_control: directed and random draw/clear requests against a position/pixel reference model.
module tb_pacman_sprite_control;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        draw = 1'b0, clear = 1'b0, load = 1'b0, shift_h = 1'b0, shift_v = 1'b0;
  logic [7:0]  load_x = '0;
  logic [6:0]  load_y = '0, shift_amount = '0;
  logic [7:0]  x_out, posx;
  logic [6:0]  y_out, posy;
  logic [11:0] colour_out;
  logic        plot, complete;

  int checks = 0;
  int errors = 0;
  int mx = 0, my = 0;
  int bm [8] = '{8'h3C, 8'h7E, 8'hF8, 8'hF0, 8'hF0, 8'hF8, 8'h7E, 8'h3C};

  pacman_sprite_control dut (
    .clk(clk), .resetn(resetn), .draw(draw), .clear(clear), .load(load),
    .load_x(load_x), .load_y(load_y), .shift_h(shift_h), .shift_v(shift_v),
    .shift_amount(shift_amount), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot), .complete(complete),
    .posx(posx), .posy(posy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // One request; model decides the new position and the expected pixel stream cycle by cycle.
  task automatic run_op(input bit dr, input bit cl, input bit ld, input bit sh, input bit sv,
                        input logic [7:0] lx, input logic [6:0] ly, input logic [6:0] sa,
                        input int abort_px);
    int ex, ey, s, first, cdone, pix, r, c8, b, plots, eplots;
    bit ep;
    plots = 0; eplots = 0;
    s = (int'(sa) >= 64) ? int'(sa) - 128 : int'(sa);
    ex = mx; ey = my;
    if (!cl) begin
      if (ld) begin
        ex = clampi(int'(lx), 152);
        ey = clampi(int'(ly), 112);
      end else begin
        if (sh) ex = clampi(mx + s, 152);
        if (sv) ey = clampi(my + s, 112);
      end
    end
    draw = dr; clear = cl; load = ld; shift_h = sh; shift_v = sv;
    load_x = lx; load_y = ly; shift_amount = sa;
    @(posedge clk); #1;
    draw = 1'b0; clear = 1'b0;
    chk("pos_before_update", posx, mx);
    first = cl ? 1 : 2;
    cdone = first + 64;
    for (int c = 1; c <= cdone; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        chk("posx", posx, ex);
        chk("posy", posy, ey);
      end
      chk("complete", complete, (c == cdone) ? 1 : 0);
      pix = c - first;
      if (pix >= 0 && pix < 64) begin
        r = pix / 8; c8 = pix % 8;
        b = (bm[r] >> (7 - c8)) & 1;
        ep = 1'b1;
`ifdef PACMAN_TRANSPARENT_EN
        if (!cl && b == 0) ep = 1'b0;
`endif
        if (ep) eplots++;
        if (plot) plots++;
        chk("plot", plot, ep);
        if (ep) begin
          chk("x_out", x_out, ex + c8);
          chk("y_out", y_out, ey + r);
          chk("colour", colour_out, (!cl && b == 1) ? 12'hFF0 : 12'h000);
        end
        if (pix == abort_px) begin
          resetn = 1'b0;
          @(posedge clk); #1;
          chk("rst_plot", plot, 0);
          chk("rst_complete", complete, 0);
          chk("rst_posx", posx, 0);
          chk("rst_posy", posy, 0);
          chk("rst_xyc", {x_out, y_out, colour_out}, 0);
          resetn = 1'b1;
          mx = 0; my = 0;
          return;
        end
      end else begin
        chk("plot_idle", plot, 0);
      end
    end
    chk("plot_count", plots, eplots);
    chk("hold_x", x_out, ex + 7);
    chk("hold_y", y_out, ey + 7);
    chk("hold_colour", colour_out, 12'h000);
    mx = ex; my = ey;
  endtask

  initial begin
    bit cl, dr;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_posx", posx, 0);
    chk("reset_posy", posy, 0);
    chk("reset_plot", plot, 0);
    chk("reset_complete", complete, 0);
    chk("reset_pixel", {x_out, y_out, colour_out}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(1, 0, 1, 0, 0, 8'd10, 7'd20, 7'd0, -1);
    run_op(1, 0, 0, 1, 1, 8'd0, 7'd0, 7'b1111101, -1);
    run_op(1, 1, 1, 0, 0, 8'd50, 7'd50, 7'd0, -1);
    run_op(1, 0, 1, 0, 0, 8'd150, 7'd5, 7'd0, -1);
    run_op(1, 0, 0, 1, 0, 8'd0, 7'd0, 7'd5, -1);
    run_op(1, 0, 1, 0, 0, 8'd2, 7'd2, 7'd0, -1);
    run_op(1, 0, 0, 0, 1, 8'd0, 7'd0, 7'b1111011, -1);
    run_op(1, 0, 1, 0, 0, 8'd255, 7'd127, 7'd0, -1);
    run_op(0, 1, 0, 0, 0, 8'd0, 7'd0, 7'd0, -1);
    run_op(1, 0, 1, 0, 0, 8'd40, 7'd50, 7'd0, 30);
    run_op(1, 0, 1, 0, 0, 8'd3, 7'd4, 7'd0, -1);

    for (int i = 0; i < 24; i++) begin
      cl = ($urandom_range(0, 4) == 0);
      dr = cl ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(dr, cl, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
